// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if - handshake bundle between the two shift requesters,
// the shared shifter and the response consumer.
//
// Signals:
//   req0_* / req1_*  request channels (valid, ready, data, shamt, arith)
//   resp_*           registered response channel (valid, ready, data, id)
//
// Modports:
//   slave   the shift_arbiter side (accepts requests, produces responses)
//   master  the environment side (issues requests, consumes responses)
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. valid must not depend on ready; ready may depend
// combinationally on valid and on the downstream ready.
interface shift_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        req0_arith;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic        req1_arith;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;

    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_arith,
        output req0_ready,
        input  req1_valid, req1_data, req1_shamt, req1_arith,
        output req1_ready,
        output resp_valid, resp_data, resp_id,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_data, req0_shamt, req0_arith,
        input  req0_ready,
        output req1_valid, req1_data, req1_shamt, req1_arith,
        input  req1_ready,
        input  resp_valid, resp_data, resp_id,
        output resp_ready
    );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter - two requesters share one 32-bit right shifter.
//
// A round-robin arbiter grants at most one request per cycle. The granted
// operand is shifted (logical or arithmetic) and loaded into a one-entry
// response register tagged with the requester id.
//
// Ports:
//   clock  sole clock, rising edge
//   reset  synchronous, active-high
//   bus    shift_arbiter_if.slave: request channels 0/1 and response channel
//
// Handshake: transfer on a rising edge where valid && ready. Request
// readies depend combinationally on resp_ready (the response register can
// be emptied and refilled in the same cycle); resp_data/resp_id are pure
// register outputs.
module shift_arbiter (
    input  logic           clock,
    input  logic           reset,
    shift_arbiter_if.slave bus
);

    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic        resp_id_q;
    // Id of the requester that last transferred; the other one wins a tie.
    logic        last_grant_q;

    logic        accept_en;
    logic        grant_valid;
    logic        grant_id;
    logic        xfer;
    logic [31:0] sel_data;
    logic [4:0]  sel_shamt;
    logic        sel_arith;
    logic [31:0] shift_result;

    // Arithmetic shift done as invert / logical shift / invert so a single
    // zero-filling shifter serves both modes.
    function automatic logic [31:0] shift_right(input logic [31:0] d,
                                                input logic [4:0]  s,
                                                input logic        a);
        if (a && d[31]) begin
            return ~((~d) >> s);
        end
        return d >> s;
    endfunction

    // The register can take a new result when empty or being drained now.
    assign accept_en = !reset && (!resp_valid_q || bus.resp_ready);

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = !last_grant_q;
        end else if (bus.req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (bus.req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    assign bus.req0_ready = accept_en && grant_valid && (grant_id == 1'b0);
    assign bus.req1_ready = accept_en && grant_valid && (grant_id == 1'b1);

    // A grant is only ever given to a valid requester, so ready implies valid.
    assign xfer = accept_en && grant_valid;

    always_comb begin
        sel_data  = bus.req0_data;
        sel_shamt = bus.req0_shamt;
        sel_arith = bus.req0_arith;
        if (grant_id) begin
            sel_data  = bus.req1_data;
            sel_shamt = bus.req1_shamt;
            sel_arith = bus.req1_arith;
        end
    end

    assign shift_result = shift_right(sel_data, sel_shamt, sel_arith);

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0000_0000;
            resp_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (xfer) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= shift_result;
            resp_id_q    <= grant_id;
            last_grant_q <= grant_id;
        end else if (resp_valid_q && bus.resp_ready) begin
            // Data and id keep their last values once consumed.
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;

endmodule
